warp_ctl_state_unit: RTL and testbench

Owns per-warp scheduler state in the core: active mask, stalled mask, thread masks and PCs. It is the producer of the warp status observed by the scheduler monitor. The unit responds to warp-control commands from the SFU warp-control path (TMC, WSPAWN, branch resolve) and to issue events from the scheduler. WSPAWN is serialized one warp per cycle by a small state machine, with backpressure on the command port.

---
 rtl/warp_ctl_state_unit_if.sv | 25 ++
 rtl/warp_ctl_state_unit.sv | 154 +++++++++++++++
 tb/tb_warp_ctl_state_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/warp_ctl_state_unit_if.sv
// Warp-control command channel: the SFU side drives the command, the state unit returns ctl_ready.
interface warp_ctl_state_unit_if #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned PC_BITS     = 30,
  parameter int unsigned NW_WIDTH    = 2
);
  logic                   ctl_valid;
  logic                   ctl_ready;
  logic [1:0]             ctl_op;
  logic [NW_WIDTH-1:0]    ctl_wid;
  logic [NUM_THREADS-1:0] ctl_tmask;
  logic [NUM_WARPS-1:0]   ctl_wspawn_mask;
  logic [PC_BITS-1:0]     ctl_pc;

  modport master (
    output ctl_valid, ctl_op, ctl_wid, ctl_tmask, ctl_wspawn_mask, ctl_pc,
    input  ctl_ready
  );

  modport slave (
    input  ctl_valid, ctl_op, ctl_wid, ctl_tmask, ctl_wspawn_mask, ctl_pc,
    output ctl_ready
  );
endinterface

// File: rtl/warp_ctl_state_unit.sv
// Per-warp scheduler state: active/stalled masks, thread masks, PCs.
// Ports: clk, reset (sync, active-high); ctl (command channel, slave);
// issue_* (scheduler issue events); active_warps, stalled_warps,
// thread_masks, warp_pcs, wspawn_busy (registered status).
module warp_ctl_state_unit #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned PC_BITS     = 30,
  parameter int unsigned NW_WIDTH    = 2,
  parameter logic [PC_BITS-1:0] STARTUP_PC = '0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  warp_ctl_state_unit_if.slave                     ctl,
  input  logic                                     issue_valid,
  input  logic [NW_WIDTH-1:0]                      issue_wid,
  input  logic [PC_BITS-1:0]                       issue_next_pc,
  input  logic                                     issue_stall,
  output logic [NUM_WARPS-1:0]                     active_warps,
  output logic [NUM_WARPS-1:0]                     stalled_warps,
  output logic [NUM_WARPS-1:0][NUM_THREADS-1:0]    thread_masks,
  output logic [NUM_WARPS-1:0][PC_BITS-1:0]        warp_pcs,
  output logic                                     wspawn_busy
);

  typedef enum logic {
    IDLE,
    SPAWN
  } state_t;

  typedef enum logic [1:0] {
    OP_TMC    = 2'b00,
    OP_WSPAWN = 2'b01,
    OP_BRANCH = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;

  state_t                                  state, state_n;
  logic [NUM_WARPS-1:0]                    spawn_mask, spawn_mask_n;
  logic [PC_BITS-1:0]                      spawn_pc, spawn_pc_n;
  logic [NW_WIDTH-1:0]                     spawn_wid, spawn_wid_n;

  logic [NUM_WARPS-1:0]                    active_n, stalled_n;
  logic [NUM_WARPS-1:0][NUM_THREADS-1:0]   tmask_n;
  logic [NUM_WARPS-1:0][PC_BITS-1:0]       pc_n;

  logic                                    cmd_fire;
  logic                                    cmd_live;
  logic [NUM_WARPS-1:0]                    eff_mask;
  logic [NUM_WARPS-1:0]                    remaining;
  logic [NW_WIDTH-1:0]                     spawn_idx;
  logic                                    found;

  assign ctl.ctl_ready = (state == IDLE);
  assign wspawn_busy   = (state == SPAWN);

  always_comb begin
    state_n      = state;
    spawn_mask_n = spawn_mask;
    spawn_pc_n   = spawn_pc;
    spawn_wid_n  = spawn_wid;
    active_n     = active_warps;
    stalled_n    = stalled_warps;
    tmask_n      = thread_masks;
    pc_n         = warp_pcs;
    spawn_idx    = '0;
    found        = 1'b0;
    remaining    = spawn_mask;

    cmd_fire = ctl.ctl_valid && (state == IDLE);
    cmd_live = cmd_fire && active_warps[ctl.ctl_wid];
    eff_mask = ctl.ctl_wspawn_mask & ~active_warps
             & ~(NUM_WARPS'(1) << ctl.ctl_wid);

    // Issue is evaluated first; a command on the same warp wins.
    if (issue_valid && active_warps[issue_wid] && !stalled_warps[issue_wid]
        && !(cmd_fire && (ctl.ctl_wid == issue_wid))) begin
      pc_n[issue_wid]      = issue_next_pc;
      stalled_n[issue_wid] = issue_stall;
    end

    if (cmd_live) begin
      case (ctl.ctl_op)
        OP_TMC: begin
          stalled_n[ctl.ctl_wid] = 1'b0;
          if (ctl.ctl_tmask == '0) begin
            active_n[ctl.ctl_wid] = 1'b0;
          end else begin
            tmask_n[ctl.ctl_wid] = ctl.ctl_tmask;
          end
        end
        OP_WSPAWN: begin
          spawn_mask_n = eff_mask;
          spawn_pc_n   = ctl.ctl_pc;
          spawn_wid_n  = ctl.ctl_wid;
          if (eff_mask == '0) begin
            stalled_n[ctl.ctl_wid] = 1'b0;
          end else begin
            state_n = SPAWN;
          end
        end
        OP_BRANCH: begin
          pc_n[ctl.ctl_wid]      = ctl.ctl_pc;
          stalled_n[ctl.ctl_wid] = 1'b0;
        end
        default: ;
      endcase
    end

    if (state == SPAWN) begin
      for (int unsigned i = 0; i < NUM_WARPS; i++) begin
        if (!found && spawn_mask[i]) begin
          found     = 1'b1;
          spawn_idx = NW_WIDTH'(i);
        end
      end
      active_n[spawn_idx]  = 1'b1;
      stalled_n[spawn_idx] = 1'b0;
      tmask_n[spawn_idx]   = NUM_THREADS'(1);
      pc_n[spawn_idx]      = spawn_pc;
      remaining            = spawn_mask & ~(NUM_WARPS'(1) << spawn_idx);
      spawn_mask_n         = remaining;
      if (remaining == '0) begin
        stalled_n[spawn_wid] = 1'b0;
        state_n              = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      spawn_mask    <= '0;
      spawn_pc      <= '0;
      spawn_wid     <= '0;
      active_warps  <= NUM_WARPS'(1);
      stalled_warps <= '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        thread_masks[w] <= (w == 0) ? NUM_THREADS'(1) : '0;
        warp_pcs[w]     <= STARTUP_PC;
      end
    end else begin
      state         <= state_n;
      spawn_mask    <= spawn_mask_n;
      spawn_pc      <= spawn_pc_n;
      spawn_wid     <= spawn_wid_n;
      active_warps  <= active_n;
      stalled_warps <= stalled_n;
      thread_masks  <= tmask_n;
      warp_pcs      <= pc_n;
    end
  end

endmodule

// File: tb/tb_warp_ctl_state_unit.sv
module tb_warp_ctl_state_unit;
  localparam int unsigned NW  = 4;
  localparam int unsigned NT  = 4;
  localparam int unsigned PCB = 30;
  localparam int unsigned NWW = 2;
  localparam logic [PCB-1:0] SPC = 30'h4;

  localparam int K_ACT  = 0;
  localparam int K_STL  = 1;
  localparam int K_TM   = 2;
  localparam int K_PC   = 3;
  localparam int K_RDY  = 4;
  localparam int K_BUSY = 5;

  typedef struct {
    string       tag;
    int          kind;
    logic [1:0]  idx;
    logic [63:0] val;
  } exp_t;

  logic clk;
  logic reset;
  logic issue_valid;
  logic [NWW-1:0] issue_wid;
  logic [PCB-1:0] issue_next_pc;
  logic issue_stall;
  logic [NW-1:0] active_warps;
  logic [NW-1:0] stalled_warps;
  logic [NW-1:0][NT-1:0] thread_masks;
  logic [NW-1:0][PCB-1:0] warp_pcs;
  logic wspawn_busy;

  int n_cmp;
  int n_fail;
  exp_t sb[$];

  warp_ctl_state_unit_if #(.NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PCB), .NW_WIDTH(NWW)) ctl_if ();

  warp_ctl_state_unit #(
    .NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PCB), .NW_WIDTH(NWW), .STARTUP_PC(SPC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ctl(ctl_if),
    .issue_valid(issue_valid),
    .issue_wid(issue_wid),
    .issue_next_pc(issue_next_pc),
    .issue_stall(issue_stall),
    .active_warps(active_warps),
    .stalled_warps(stalled_warps),
    .thread_masks(thread_masks),
    .warp_pcs(warp_pcs),
    .wspawn_busy(wspawn_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] observe(int kind, logic [1:0] idx);
    case (kind)
      K_ACT:   return 64'(active_warps);
      K_STL:   return 64'(stalled_warps);
      K_TM:    return 64'(thread_masks[idx]);
      K_PC:    return 64'(warp_pcs[idx]);
      K_RDY:   return 64'(ctl_if.ctl_ready);
      default: return 64'(wspawn_busy);
    endcase
  endfunction

  task automatic expect_v(string tag, int kind, logic [1:0] idx, logic [63:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind, e.idx);
      n_cmp++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ctl_if.ctl_valid = 1'b0;
    issue_valid      = 1'b0;
  endtask

  task automatic cmd(logic [1:0] op, logic [NWW-1:0] wid, logic [NT-1:0] tm,
                     logic [NW-1:0] mask, logic [PCB-1:0] pc);
    ctl_if.ctl_valid       = 1'b1;
    ctl_if.ctl_op          = op;
    ctl_if.ctl_wid         = wid;
    ctl_if.ctl_tmask       = tm;
    ctl_if.ctl_wspawn_mask = mask;
    ctl_if.ctl_pc          = pc;
  endtask

  task automatic issue(logic [NWW-1:0] wid, logic [PCB-1:0] pc, logic stall);
    issue_valid   = 1'b1;
    issue_wid     = wid;
    issue_next_pc = pc;
    issue_stall   = stall;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    ctl_if.ctl_valid = 1'b0;
    ctl_if.ctl_op = 2'b00;
    ctl_if.ctl_wid = '0;
    ctl_if.ctl_tmask = '0;
    ctl_if.ctl_wspawn_mask = '0;
    ctl_if.ctl_pc = '0;
    issue_valid = 1'b0;
    issue_wid = '0;
    issue_next_pc = '0;
    issue_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    expect_v("rst_act", K_ACT, 0, 64'h1);
    expect_v("rst_stl", K_STL, 0, 64'h0);
    expect_v("rst_tm0", K_TM, 0, 64'h1);
    for (int w = 1; w < 4; w++) expect_v("rst_tmN", K_TM, 2'(w), 64'h0);
    for (int w = 0; w < 4; w++) expect_v("rst_pc", K_PC, 2'(w), 64'(SPC));
    expect_v("rst_rdy", K_RDY, 0, 64'h1);
    expect_v("rst_busy", K_BUSY, 0, 64'h0);
    drain();

    // issue with stall
    issue(0, 30'h10, 1'b1);
    tick(); idle_in();
    expect_v("iss_stl", K_STL, 0, 64'h1);
    expect_v("iss_pc0", K_PC, 0, 64'h10);
    drain();

    // issue to stalled warp ignored
    issue(0, 30'h20, 1'b0);
    tick(); idle_in();
    expect_v("iss_stalled_pc0", K_PC, 0, 64'h10);
    expect_v("iss_stalled_stl", K_STL, 0, 64'h1);
    drain();

    // branch
    cmd(2'b10, 0, 4'h0, 4'h0, 30'h40);
    tick(); idle_in();
    expect_v("br_stl", K_STL, 0, 64'h0);
    expect_v("br_pc0", K_PC, 0, 64'h40);
    expect_v("br_rdy", K_RDY, 0, 64'h1);
    drain();

    // stall requestor, then spawn 3 warps
    issue(0, 30'h44, 1'b1);
    tick(); idle_in();
    expect_v("pre_sp_stl", K_STL, 0, 64'h1);
    drain();
    cmd(2'b01, 0, 4'h0, 4'hF, 30'h80);
    tick(); idle_in();
    expect_v("sp_t1_rdy", K_RDY, 0, 64'h0);
    expect_v("sp_t1_busy", K_BUSY, 0, 64'h1);
    expect_v("sp_t1_act", K_ACT, 0, 64'h1);
    drain();
    issue(1, 30'h99, 1'b1);
    tick(); idle_in();
    expect_v("sp_t2_act", K_ACT, 0, 64'h3);
    expect_v("sp_t2_pc1", K_PC, 1, 64'h80);
    expect_v("sp_t2_tm1", K_TM, 1, 64'h1);
    expect_v("sp_t2_stl", K_STL, 0, 64'h1);
    expect_v("sp_t2_rdy", K_RDY, 0, 64'h0);
    drain();
    tick();
    expect_v("sp_t3_act", K_ACT, 0, 64'h7);
    expect_v("sp_t3_pc2", K_PC, 2, 64'h80);
    expect_v("sp_t3_rdy", K_RDY, 0, 64'h0);
    drain();
    tick();
    expect_v("sp_t4_act", K_ACT, 0, 64'hF);
    expect_v("sp_t4_pc3", K_PC, 3, 64'h80);
    expect_v("sp_t4_tm3", K_TM, 3, 64'h1);
    expect_v("sp_t4_stl", K_STL, 0, 64'h0);
    expect_v("sp_t4_rdy", K_RDY, 0, 64'h1);
    expect_v("sp_t4_busy", K_BUSY, 0, 64'h0);
    drain();

    // TMC and issue on different warps
    cmd(2'b00, 1, 4'hA, 4'h0, 30'h0);
    issue(2, 30'h200, 1'b0);
    tick(); idle_in();
    expect_v("tmc_tm1", K_TM, 1, 64'hA);
    expect_v("tmc_iss_pc2", K_PC, 2, 64'h200);
    expect_v("tmc_iss_stl", K_STL, 0, 64'h0);
    drain();

    // branch and issue on the same warp: branch wins
    cmd(2'b10, 2, 4'h0, 4'h0, 30'h300);
    issue(2, 30'h310, 1'b1);
    tick(); idle_in();
    expect_v("coll_pc2", K_PC, 2, 64'h300);
    expect_v("coll_stl", K_STL, 0, 64'h0);
    drain();

    // TMC zero deactivates, keeps tmask
    cmd(2'b00, 1, 4'h0, 4'h0, 30'h0);
    tick(); idle_in();
    expect_v("tmc0_act", K_ACT, 0, 64'hD);
    expect_v("tmc0_tm1", K_TM, 1, 64'hA);
    drain();

    // branch to inactive warp discarded
    cmd(2'b10, 1, 4'h0, 4'h0, 30'h500);
    tick(); idle_in();
    expect_v("br_inact_pc1", K_PC, 1, 64'h80);
    drain();

    // reserved op discarded
    cmd(2'b11, 0, 4'hF, 4'hF, 30'h555);
    tick(); idle_in();
    expect_v("rsvd_act", K_ACT, 0, 64'hD);
    expect_v("rsvd_pc0", K_PC, 0, 64'h44);
    expect_v("rsvd_tm0", K_TM, 0, 64'h1);
    expect_v("rsvd_rdy", K_RDY, 0, 64'h1);
    drain();

    // reduce to warps 0,1 active
    cmd(2'b00, 2, 4'h0, 4'h0, 30'h0);
    tick();
    cmd(2'b00, 3, 4'h0, 4'h0, 30'h0);
    tick();
    cmd(2'b01, 0, 4'h0, 4'h2, 30'h600);
    tick(); idle_in();
    expect_v("sp1_rdy", K_RDY, 0, 64'h0);
    drain();
    tick();
    expect_v("sp1_act", K_ACT, 0, 64'h3);
    expect_v("sp1_pc1", K_PC, 1, 64'h600);
    expect_v("sp1_rdy2", K_RDY, 0, 64'h1);
    drain();

    // spawn with empty effective mask
    issue(0, 30'h48, 1'b1);
    tick(); idle_in();
    expect_v("eff0_pre_stl", K_STL, 0, 64'h1);
    drain();
    cmd(2'b01, 0, 4'h0, 4'h3, 30'h700);
    tick(); idle_in();
    expect_v("eff0_stl", K_STL, 0, 64'h0);
    expect_v("eff0_rdy", K_RDY, 0, 64'h1);
    expect_v("eff0_busy", K_BUSY, 0, 64'h0);
    expect_v("eff0_act", K_ACT, 0, 64'h3);
    expect_v("eff0_pc1", K_PC, 1, 64'h600);
    drain();
    tick();
    expect_v("eff0_rdy2", K_RDY, 0, 64'h1);
    drain();

    // reset in the middle of a 3-warp spawn
    cmd(2'b00, 1, 4'h0, 4'h0, 30'h0);
    tick();
    cmd(2'b01, 0, 4'h0, 4'hE, 30'h800);
    tick(); idle_in();
    expect_v("rs_t1_rdy", K_RDY, 0, 64'h0);
    expect_v("rs_t1_act", K_ACT, 0, 64'h1);
    drain();
    tick();
    expect_v("rs_t2_act", K_ACT, 0, 64'h3);
    expect_v("rs_t2_rdy", K_RDY, 0, 64'h0);
    drain();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_v("rs_act", K_ACT, 0, 64'h1);
    expect_v("rs_stl", K_STL, 0, 64'h0);
    expect_v("rs_tm0", K_TM, 0, 64'h1);
    expect_v("rs_tm1", K_TM, 1, 64'h0);
    expect_v("rs_pc0", K_PC, 0, 64'(SPC));
    expect_v("rs_pc1", K_PC, 1, 64'(SPC));
    expect_v("rs_rdy", K_RDY, 0, 64'h1);
    expect_v("rs_busy", K_BUSY, 0, 64'h0);
    drain();
    tick();
    expect_v("rs_hold_act", K_ACT, 0, 64'h1);
    expect_v("rs_hold_rdy", K_RDY, 0, 64'h1);
    drain();
    cmd(2'b01, 0, 4'h0, 4'h2, 30'h900);
    tick(); idle_in();
    expect_v("rs_new_rdy", K_RDY, 0, 64'h0);
    expect_v("rs_new_busy", K_BUSY, 0, 64'h1);
    drain();
    tick();
    expect_v("rs_new_act", K_ACT, 0, 64'h3);
    expect_v("rs_new_pc1", K_PC, 1, 64'h900);
    expect_v("rs_new_rdy2", K_RDY, 0, 64'h1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
